// File: rtl/thresh_slew_ctrl.sv
// Threshold register owner for dual_PWM: accepts VIL/VIH update commands and slews the
// selected threshold 1 LSB per STEP_CYC clocks toward the target, keeping VIL <= VIH.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_rdy=1
// RAMP  | stepping the selected output toward tgt once per STEP_CYC clocks
// DONE  | target reached, done pulses for this single cycle
module thresh_slew_ctrl #(
    parameter int unsigned STEP_CYC = 256,
    parameter logic [7:0]  VIL_RST  = 8'h40,
    parameter logic [7:0]  VIH_RST  = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_vld,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_data,
    output logic       cmd_rdy,
    output logic [7:0] VIL,
    output logic [7:0] VIH,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned   TW     = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(STEP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [7:0]    tgt;
    logic          sel_q;

    logic       accept;
    logic       reject;
    logic       take;
    logic [7:0] cmd_cur;
    logic [7:0] ramp_cur;
    logic [7:0] ramp_nxt;
    logic       tick;

    // Reject checks use the static (unselected) output, so the ramp can never cross it.
    assign accept   = cmd_vld && (state == S_IDLE);
    assign reject   = cmd_sel ? (cmd_data < VIL) : (cmd_data > VIH);
    assign take     = accept && !reject;
    assign cmd_cur  = cmd_sel ? VIH : VIL;
    assign ramp_cur = sel_q ? VIH : VIL;
    assign ramp_nxt = (tgt > ramp_cur) ? ramp_cur + 8'd1 : ramp_cur - 8'd1;
    assign tick     = (timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take) begin
                    state_nxt = (cmd_data == cmd_cur) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                if (tick && (ramp_nxt == tgt)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VIL   <= VIL_RST;
            VIH   <= VIH_RST;
            tgt   <= '0;
            sel_q <= 1'b0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            err <= accept && reject;
            if (take) begin
                tgt   <= cmd_data;
                sel_q <= cmd_sel;
                timer <= '0;
            end else if (state == S_RAMP) begin
                if (tick) begin
                    timer <= '0;
                    if (sel_q) begin
                        VIH <= ramp_nxt;
                    end else begin
                        VIL <= ramp_nxt;
                    end
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_thresh_slew_ctrl.sv
// Bench for thresh_slew_ctrl: directed command table, held-command and mid-ramp reset
// sequences, then random commands checked every cycle against an elapsed-time model.
module tb_thresh_slew_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_vld;
    logic       cmd_sel;
    logic [7:0] cmd_data;
    logic       cmd_rdy;
    logic [7:0] VIL;
    logic [7:0] VIH;
    logic       busy;
    logic       done;
    logic       err;

    thresh_slew_ctrl #(.STEP_CYC(S), .VIL_RST(8'h40), .VIH_RST(8'hC0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd_vld (cmd_vld),
        .cmd_sel (cmd_sel),
        .cmd_data(cmd_data),
        .cmd_rdy (cmd_rdy),
        .VIL     (VIL),
        .VIH     (VIH),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after an accepted command, the output equals start moved by
    // min(elapsed/S, distance) toward the target; done lands at distance*S edges.
    logic [7:0] m_vil, m_vih;
    bit         m_act, m_err, m_sel;
    int         m_cnt, m_n, m_start, m_tgt, moved, val;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_vil = 8'h40;
            m_vih = 8'hC0;
            m_act = 0;
            m_err = 0;
        end else begin
            m_err = 0;
            if (m_act) begin
                m_cnt++;
                if (m_cnt > m_n * S) m_act = 0;
            end else if (cmd_vld) begin
                if (cmd_sel ? (cmd_data < m_vil) : (cmd_data > m_vih)) begin
                    m_err = 1;
                end else begin
                    m_act   = 1;
                    m_cnt   = 0;
                    m_sel   = cmd_sel;
                    m_tgt   = int'(cmd_data);
                    m_start = cmd_sel ? int'(m_vih) : int'(m_vil);
                    m_n     = (m_tgt > m_start) ? m_tgt - m_start : m_start - m_tgt;
                end
            end
            if (m_act) begin
                moved = m_cnt / S;
                if (moved > m_n) moved = m_n;
                val = (m_tgt >= m_start) ? m_start + moved : m_start - moved;
                if (m_sel) m_vih = 8'(val);
                else       m_vil = 8'(val);
            end
        end
        #1;
        if (chk_en) begin
            chk("mon_vil",  int'(VIL),  int'(m_vil));
            chk("mon_vih",  int'(VIH),  int'(m_vih));
            chk("mon_done", int'(done), int'(m_act && (m_cnt == m_n * S)));
            chk("mon_busy", int'(busy), int'(m_act));
            chk("mon_rdy",  int'(cmd_rdy), int'(!m_act));
            chk("mon_err",  int'(err),  int'(m_err));
            chk("mon_order", int'(VIL <= VIH), 1);
        end
    end

    typedef struct {
        logic       sel;
        logic [7:0] data;
        bit         exp_err;
        int         steps;
        logic [7:0] exp_vil;
        logic [7:0] exp_vih;
    } vec_t;

    vec_t vecs[$];

    // Entered and left at 2 time units after a posedge.
    task automatic do_cmd(input vec_t v);
        int n;
        n = 0;
        while (!cmd_rdy && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("cmd_rdy_wait", int'(cmd_rdy), 1);
        cmd_sel  = v.sel;
        cmd_data = v.data;
        cmd_vld  = 1'b1;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        if (v.exp_err) begin
            chk("rej_err",  int'(err), 1);
            chk("rej_rdy",  int'(cmd_rdy), 1);
            chk("rej_busy", int'(busy), 0);
            chk("rej_done", int'(done), 0);
            @(posedge clk); #1;
            chk("rej_err_clr", int'(err), 0);
        end else begin
            chk("acc_busy", int'(busy), 1);
            chk("acc_rdy",  int'(cmd_rdy), 0);
            n = 0;
            while (!done && n < v.steps * S + 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("done_latency", n, v.steps * S);
            chk("done_seen", int'(done), 1);
            @(posedge clk); #1;
            chk("done_clr", int'(done), 0);
            chk("rdy_back", int'(cmd_rdy), 1);
        end
        chk("vec_vil", int'(VIL), int'(v.exp_vil));
        chk("vec_vih", int'(VIH), int'(v.exp_vih));
        #1;
    endtask

    initial begin
        int         n_done;
        bit         saw, hold;
        logic [7:0] base;

        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_sel  = 1'b0;
        cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_vil",  int'(VIL), 8'h40);
        chk("rst_vih",  int'(VIH), 8'hC0);
        chk("rst_rdy",  int'(cmd_rdy), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err",  int'(err), 0);
        chk_en = 1;
        #1;

        vecs.push_back('{1'b0, 8'h40, 0, 0,   8'h40, 8'hC0});
        vecs.push_back('{1'b0, 8'h3F, 0, 1,   8'h3F, 8'hC0});
        vecs.push_back('{1'b1, 8'hC3, 0, 3,   8'h3F, 8'hC3});
        vecs.push_back('{1'b0, 8'hD0, 1, 0,   8'h3F, 8'hC3});
        vecs.push_back('{1'b1, 8'h3E, 1, 0,   8'h3F, 8'hC3});
        vecs.push_back('{1'b0, 8'h42, 0, 3,   8'h42, 8'hC3});
        vecs.push_back('{1'b1, 8'h42, 0, 129, 8'h42, 8'h42});
        vecs.push_back('{1'b0, 8'h43, 1, 0,   8'h42, 8'h42});
        vecs.push_back('{1'b0, 8'h40, 0, 2,   8'h40, 8'h42});
        vecs.push_back('{1'b1, 8'h3F, 1, 0,   8'h40, 8'h42});
        foreach (vecs[i]) do_cmd(vecs[i]);

        // Command held valid across a ramp is taken once, after cmd_rdy returns.
        rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;
        cmd_sel  = 1'b0;
        cmd_data = 8'h3E;
        cmd_vld  = 1'b1;
        @(posedge clk); #1;
        chk("hold_busy", int'(busy), 1);
        #1;
        cmd_sel  = 1'b1;
        cmd_data = 8'hBF;
        n_done = 0;
        saw    = 0;
        hold   = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (hold && saw) begin
                cmd_vld = 1'b0;
                hold    = 0;
            end else if (n_done == 1 && cmd_rdy) begin
                saw = 1;
            end
        end
        cmd_vld = 1'b0;
        chk("hold_done_cnt", n_done, 2);
        chk("hold_vil", int'(VIL), 8'h3E);
        chk("hold_vih", int'(VIH), 8'hBF);
        #1;

        // Reset mid-ramp snaps outputs back and produces no done.
        rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;
        cmd_sel  = 1'b1;
        cmd_data = 8'hC3;
        cmd_vld  = 1'b1;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (VIH == 8'hC1) break;
        end
        chk("mid_vih_c1", int'(VIH), 8'hC1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vih",  int'(VIH), 8'hC0);
        chk("mid_rst_vil",  int'(VIL), 8'h40);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("mid_no_done", n_done, 0);
        chk("mid_idle_vih", int'(VIH), 8'hC0);
        #1;

        // Random commands near the current thresholds, occasionally anywhere.
        for (int i = 0; i < 3000; i++) begin
            cmd_vld = ($urandom_range(0, 2) == 0);
            cmd_sel = 1'($urandom_range(0, 1));
            base    = cmd_sel ? m_vih : m_vil;
            if ($urandom_range(0, 15) == 0) cmd_data = 8'($urandom_range(0, 255));
            else                            cmd_data = base + 8'($urandom_range(0, 6)) - 8'd3;
            @(posedge clk); #2;
        end
        cmd_vld = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (cmd_rdy) break;
            @(posedge clk); #2;
        end
        chk("final_idle", int'(cmd_rdy), 1);
        @(posedge clk); #2;
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
